// File: rtl/dma_job_tracker.sv
// Tags frontend jobs with incrementing transfer IDs, holds them in a one-deep output
// register, and tracks retirements. Optional completion IRQ: DMA_JOB_TRACKER_IRQ_EN.
module dma_job_tracker #(
  parameter int unsigned JobWidth       = 64,
  parameter int unsigned IdWidth        = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [JobWidth-1:0] job_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  output logic [JobWidth-1:0] job_o,
  output logic [IdWidth-1:0]  job_id_o,
  output logic                job_valid_o,
  input  logic                job_ready_i,
  input  logic                retire_i,
  output logic [IdWidth-1:0]  next_id_o,
  output logic [IdWidth-1:0]  done_id_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                busy_o,
  output logic                retire_err_o,
  input  logic                irq_clr_i,
  output logic                irq_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic [JobWidth-1:0] job_q, job_d;
  logic [IdWidth-1:0]  job_id_q, job_id_d;
  logic                job_valid_q, job_valid_d;
  logic [IdWidth-1:0]  next_id_q, next_id_d;
  logic [IdWidth-1:0]  done_id_q, done_id_d;
  logic [CntWidth-1:0] outst_q, outst_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                accept, retire_ok;

  // Full-check uses the registered count only, so a same-cycle retire cannot bypass it.
  assign job_ready_o = (outst_q < MaxCnt) && (!job_valid_q || job_ready_i);
  assign accept      = job_valid_i && job_ready_o;
  assign retire_ok   = retire_i && (outst_q != '0);

  always_comb begin
    job_d       = job_q;
    job_id_d    = job_id_q;
    job_valid_d = job_valid_q;
    next_id_d   = next_id_q;
    done_id_d   = done_id_q;
    outst_d     = outst_q;
    err_d       = err_q;
    if (accept) begin
      job_d       = job_i;
      job_id_d    = next_id_q;
      job_valid_d = 1'b1;
      next_id_d   = next_id_q + 1'b1;
    end else if (job_ready_i) begin
      job_valid_d = 1'b0;
    end
    if (retire_ok) done_id_d = done_id_q + 1'b1;
    if (retire_i && outst_q == '0) err_d = 1'b1;
    case ({accept, retire_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    busy_d = (outst_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      job_q       <= '0;
      job_id_q    <= '0;
      job_valid_q <= 1'b0;
      next_id_q   <= IdWidth'(1);
      done_id_q   <= '0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      job_q       <= job_d;
      job_id_q    <= job_id_d;
      job_valid_q <= job_valid_d;
      next_id_q   <= next_id_d;
      done_id_q   <= done_id_d;
      outst_q     <= outst_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

`ifdef DMA_JOB_TRACKER_IRQ_EN
  logic irq_q, irq_d;

  // Drain-to-zero set has priority over a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr_i) irq_d = 1'b0;
    if (retire_ok && outst_d == '0) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

  assign job_o         = job_q;
  assign job_id_o      = job_id_q;
  assign job_valid_o   = job_valid_q;
  assign next_id_o     = next_id_q;
  assign done_id_o     = done_id_q;
  assign outstanding_o = outst_q;
  assign busy_o        = busy_q;
  assign retire_err_o  = err_q;

endmodule

// File: doc/dma_job_tracker.md
Name: dma_job_tracker

Overview:
Stage between the DMA register frontend and the job FIFO / nd-midend.
- Accepts jobs from the frontend, tags each with a monotonically increasing transfer ID, and forwards them through a one-deep output register.
- Counts retirements from the backend/midend response path and exposes `next_id_o`, `done_id_o` and `busy_o` for the frontend's ID/status registers.
- Caps the number of outstanding jobs and optionally raises a completion interrupt.

Parameters:
- JobWidth, 64, width of the opaque job payload (packed nd request).
- IdWidth, 32, width of the transfer ID counters.
- MaxOutstanding, 4, maximum jobs accepted but not yet retired (1..255).
- CntWidth, $clog2(MaxOutstanding+1), localparam, outstanding counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- job_i  in  JobWidth  job payload from frontend
- job_valid_i  in  1  job valid
- job_ready_o  out  1  job accepted when valid&ready
- job_o  out  JobWidth  registered job payload to FIFO/midend
- job_id_o  out  IdWidth  ID assigned to job_o
- job_valid_o  out  1  output valid
- job_ready_i  in  1  downstream ready
- retire_i  in  1  one-cycle pulse per completed job (rsp valid&ready)
- next_id_o  out  IdWidth  ID the next accepted job will receive
- done_id_o  out  IdWidth  ID of most recently retired job
- outstanding_o  out  CntWidth  jobs accepted, not retired
- busy_o  out  1  outstanding_o != 0
- retire_err_o  out  1  sticky: retire seen with zero outstanding
- irq_clr_i  in  1  clear completion interrupt
- irq_o  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset (rst_ni low at a clk_i edge): job_valid_o=0, job_o=0, job_id_o=0, next_id_o=1, done_id_o=0, outstanding_o=0, busy_o=0, retire_err_o=0, irq_o=0.
- Reset mid-operation discards any held output job; no partial state survives.
- job_ready_o = (outstanding_q < MaxOutstanding) && (!job_valid_o || job_ready_i). Combinational, and never depends on job_valid_i.
- Accept (job_valid_i && job_ready_o), registered on the clock edge:
  - job_o <= job_i; job_id_o <= next_id; job_valid_o <= 1.
  - next_id <= next_id+1, wrapping modulo 2^IdWidth, including wrap to 0.
  - outstanding += 1.
- Latency: input to output is 1 cycle. Back-to-back acceptance is allowed when job_ready_i=1 (full throughput).
- Output handshake:
  - While job_valid_o && !job_ready_i, job_o and job_id_o stay stable; AXI-stream rules apply.
  - Output consumed without a new accept: job_valid_o <= 0.
- Retire (retire_i=1):
  - With outstanding>0: done_id <= done_id+1 (modulo 2^IdWidth); outstanding -= 1.
  - With outstanding==0: counters unchanged; retire_err_o <= 1, sticky until reset.
- Accept and valid retire in the same cycle: outstanding unchanged; both ID counters advance.
- An accepted job counts as outstanding from the cycle after acceptance, whether still held in the output register or already downstream.
- Full (outstanding==MaxOutstanding): job_ready_o=0. A retire in that cycle does not bypass combinationally; acceptance resumes the next cycle.
- busy_o is a registered compare, valid the same cycle as outstanding_o.
- Invariant: next_id - done_id - 1 == outstanding (modulo 2^IdWidth).

Optional Feature:
- Macro: DMA_JOB_TRACKER_IRQ_EN.
- Defined: irq_o is a level interrupt.
  - Set the cycle after a valid retire that brings outstanding to 0 (the last job drains).
  - Cleared by irq_clr_i.
  - Set wins over a simultaneous clear.
  - Reset 0.
- Not defined: irq_o tied to 0; irq_clr_i ignored; no IRQ flop synthesized.

Test Plan:
- Reset then idle: next_id_o=1, done_id_o=0, busy_o=0, job_ready_o=1, job_valid_o=0.
- 3 jobs back-to-back (payloads 0xA,0xB,0xC), job_ready_i=1 → job_o appears 1 cycle later with job_id_o=1,2,3; outstanding_o=3; next_id_o=4.
- MaxOutstanding=4, 4 jobs accepted, no retire → job_ready_o=0. One retire_i → next cycle job_ready_o=1 and done_id_o=1.
- Backpressure: job_ready_i=0 for 5 cycles with job_o=0x55 held → job_o/job_id_o stable, job_ready_o=0. Release → job consumed, new job accepted the same cycle.
- Simultaneous accept and retire with outstanding=2 → outstanding stays 2; next_id_o and done_id_o each +1.
- retire_i with outstanding=0 → retire_err_o=1, done_id_o unchanged.
- ID wrap (IdWidth=4): 16 accepts from next_id=1 → IDs wrap to 0 then 1.
- With DMA_JOB_TRACKER_IRQ_EN: 2 jobs, 2 retires → irq_o=1 one cycle after the second retire; irq_clr_i → 0.
- Without DMA_JOB_TRACKER_IRQ_EN: same sequence → irq_o stays 0.
